mor1kx_pcu_sampler: RTL and testbench

Periodic snapshot engine for the performance counter unit. It sits between the CPU SPR bus and the PCU's SPR port. On a programmable period or an explicit trigger, it sweeps the selected PCCR counters with SPR reads, giving the CPU absolute priority on the shared port. Samples are buffered in a FIFO and drained over a valid/ready stream to trace or debug logic.

---
 rtl/mor1kx_pcu_sampler.sv | 198 +++++++++++++++++++
 tb/tb_mor1kx_pcu_sampler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_pcu_sampler.sv
// Periodic/triggered snapshot engine for the PCU counters: sweeps PCCRn over the shared SPR
// port (CPU has priority) and buffers {idx, value, last} samples in a FIFO drained as a stream.
module mor1kx_pcu_sampler #(
  parameter int unsigned OPTION_PERFCOUNTERS_NUM = 7,
  parameter int unsigned PERIOD_WIDTH            = 16,
  parameter int unsigned FIFO_DEPTH_LOG2         = 3
) (
  input  logic                               clk,
  input  logic                               rst,

  input  logic                               cpu_spr_access_i,
  input  logic                               cpu_spr_we_i,
  input  logic                               cpu_spr_re_i,
  input  logic [15:0]                        cpu_spr_addr_i,
  input  logic [31:0]                        cpu_spr_dat_i,
  output logic                               cpu_spr_ack_o,
  output logic [31:0]                        cpu_spr_dat_o,

  output logic                               pcu_spr_access_o,
  output logic                               pcu_spr_we_o,
  output logic                               pcu_spr_re_o,
  output logic [15:0]                        pcu_spr_addr_o,
  output logic [31:0]                        pcu_spr_dat_o,
  input  logic                               pcu_spr_ack_i,
  input  logic [31:0]                        pcu_spr_dat_i,

  input  logic                               enable_i,
  input  logic [PERIOD_WIDTH-1:0]            period_i,
  input  logic                               trigger_i,
  input  logic [OPTION_PERFCOUNTERS_NUM:0]   mask_i,

  output logic                               sample_valid_o,
  input  logic                               sample_ready_i,
  output logic [31:0]                        sample_data_o,
  output logic [2:0]                         sample_idx_o,
  output logic                               sample_last_o,
  output logic                               busy_o,
  output logic [7:0]                         overrun_cnt_o
);

  localparam int unsigned FifoDepth    = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned CntW         = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] FifoFull = CntW'(FifoDepth);
  localparam logic [2:0] IdxLast       = 3'(OPTION_PERFCOUNTERS_NUM);
  localparam logic [15:0] PccrBaseAddr = 16'h3800;

  typedef enum logic {StIdle, StScan} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic                        pending_q, pending_d;
  logic [7:0]                  overrun_q, overrun_d;
  logic [PERIOD_WIDTH-1:0]     timer_q, timer_d;
  logic                        timer_tick, tick;

  logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             cnt_q;
  logic [35:0]                 mem_q [FifoDepth];
  logic                        fifo_full, push, pop;

  logic                        smp_req, consume, advance, sel_last;
  logic [OPTION_PERFCOUNTERS_NUM:0] above_mask;

  // Timer is parked at zero while disabled so the first enabled cycle ticks.
  always_comb begin
    timer_d    = '0;
    timer_tick = 1'b0;
    if (enable_i && (period_i != '0)) begin
      if (timer_q == '0) begin
        timer_tick = 1'b1;
        timer_d    = period_i - PERIOD_WIDTH'(1);
      end else begin
        timer_d    = timer_q - PERIOD_WIDTH'(1);
      end
    end
  end

  assign tick = timer_tick | trigger_i;

  assign above_mask = (mask_i >> idx_q) >> 1;
  assign sel_last   = ~|above_mask;
  assign fifo_full  = (cnt_q == FifoFull);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    smp_req   = 1'b0;
    push      = 1'b0;
    consume   = 1'b0;
    advance   = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      StIdle: begin
        if (pending_q) begin
          consume = 1'b1;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (!mask_i[idx_q]) begin
          advance = 1'b1;
        end else if (!cpu_spr_access_i && !fifo_full) begin
          smp_req = 1'b1;
          if (pcu_spr_ack_i) begin
            push    = 1'b1;
            advance = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Sweep ends after the highest selected counter or at the last index.
    if (advance) begin
      if ((idx_q == IdxLast) || (push && sel_last)) begin
        state_d = StIdle;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    pending_d = tick ? 1'b1 : (consume ? 1'b0 : pending_q);
    if (tick && pending_q && (overrun_q != 8'hff)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      timer_q   <= timer_d;
    end
  end

  // SPR port arbitration: the CPU always wins.
  always_comb begin
    pcu_spr_access_o = 1'b0;
    pcu_spr_we_o     = 1'b0;
    pcu_spr_re_o     = 1'b0;
    pcu_spr_addr_o   = '0;
    pcu_spr_dat_o    = '0;
    if (cpu_spr_access_i) begin
      pcu_spr_access_o = 1'b1;
      pcu_spr_we_o     = cpu_spr_we_i;
      pcu_spr_re_o     = cpu_spr_re_i;
      pcu_spr_addr_o   = cpu_spr_addr_i;
      pcu_spr_dat_o    = cpu_spr_dat_i;
    end else if (smp_req) begin
      pcu_spr_access_o = 1'b1;
      pcu_spr_re_o     = 1'b1;
      pcu_spr_addr_o   = PccrBaseAddr + 16'(idx_q);
    end
  end

  assign cpu_spr_ack_o = cpu_spr_access_i & pcu_spr_ack_i;
  assign cpu_spr_dat_o = cpu_spr_access_i ? pcu_spr_dat_i : 32'd0;

  assign pop = sample_valid_o & sample_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {idx_q, pcu_spr_dat_i, sel_last};
  end

  assign sample_valid_o = (cnt_q != '0);
  assign sample_idx_o   = sample_valid_o ? mem_q[rd_ptr_q][35:33] : 3'd0;
  assign sample_data_o  = sample_valid_o ? mem_q[rd_ptr_q][32:1]  : 32'd0;
  assign sample_last_o  = sample_valid_o ? mem_q[rd_ptr_q][0]     : 1'b0;
  assign busy_o         = (state_q == StScan);
  assign overrun_cnt_o  = overrun_q;

endmodule

// File: tb/tb_mor1kx_pcu_sampler.sv
// Scoreboarded bench for mor1kx_pcu_sampler: directed scenarios plus a randomized sweep phase
// against a PCU register model and per-sweep expected sample lists.
module tb_mor1kx_pcu_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_spr_access_i, cpu_spr_we_i, cpu_spr_re_i;
  logic [15:0] cpu_spr_addr_i;
  logic [31:0] cpu_spr_dat_i;
  logic        cpu_spr_ack_o;
  logic [31:0] cpu_spr_dat_o;
  logic        pcu_spr_access_o, pcu_spr_we_o, pcu_spr_re_o;
  logic [15:0] pcu_spr_addr_o;
  logic [31:0] pcu_spr_dat_o;
  logic        pcu_spr_ack_i;
  logic [31:0] pcu_spr_dat_i;
  logic        enable_i;
  logic [15:0] period_i;
  logic        trigger_i;
  logic [7:0]  mask_i;
  logic        sample_valid_o, sample_ready_i;
  logic [31:0] sample_data_o;
  logic [2:0]  sample_idx_o;
  logic        sample_last_o, busy_o;
  logic [7:0]  overrun_cnt_o;

  mor1kx_pcu_sampler #(
    .OPTION_PERFCOUNTERS_NUM(7),
    .PERIOD_WIDTH(16),
    .FIFO_DEPTH_LOG2(3)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_spr_access_i(cpu_spr_access_i), .cpu_spr_we_i(cpu_spr_we_i),
    .cpu_spr_re_i(cpu_spr_re_i), .cpu_spr_addr_i(cpu_spr_addr_i),
    .cpu_spr_dat_i(cpu_spr_dat_i), .cpu_spr_ack_o(cpu_spr_ack_o),
    .cpu_spr_dat_o(cpu_spr_dat_o),
    .pcu_spr_access_o(pcu_spr_access_o), .pcu_spr_we_o(pcu_spr_we_o),
    .pcu_spr_re_o(pcu_spr_re_o), .pcu_spr_addr_o(pcu_spr_addr_o),
    .pcu_spr_dat_o(pcu_spr_dat_o), .pcu_spr_ack_i(pcu_spr_ack_i),
    .pcu_spr_dat_i(pcu_spr_dat_i),
    .enable_i(enable_i), .period_i(period_i), .trigger_i(trigger_i), .mask_i(mask_i),
    .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
    .sample_data_o(sample_data_o), .sample_idx_o(sample_idx_o),
    .sample_last_o(sample_last_o), .busy_o(busy_o), .overrun_cnt_o(overrun_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
    logic        last;
  } smp_t;

  smp_t        exp_q[$];
  smp_t        e;
  logic [31:0] pccr [8];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;
  int          pop_cnt = 0;
  logic        busy_prev = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          rand_cpu = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // PCU model: PCCR0..7 hold pccr[], anything else reads back a tagged address.
  function automatic logic [31:0] model_dat(input logic [15:0] addr);
    if (addr[15:3] == 13'h0700) return pccr[addr[2:0]];
    return {16'hdead, addr};
  endfunction

  always_comb begin
    pcu_spr_ack_i = pcu_spr_access_o;
    pcu_spr_dat_i = model_dat(pcu_spr_addr_o);
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: arbitration checks every cycle, sample pops against the scoreboard,
  // and a fresh expected list per sweep start.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy_prev = 1'b0;
    end else begin
      if (cpu_spr_access_i) begin
        chk("arb_cpu_pass", {pcu_spr_access_o, pcu_spr_we_o, pcu_spr_re_o, pcu_spr_addr_o,
            pcu_spr_dat_o}, {1'b1, cpu_spr_we_i, cpu_spr_re_i, cpu_spr_addr_i, cpu_spr_dat_i});
        chk("cpu_ack", cpu_spr_ack_o, 1'b1);
        chk("cpu_dat", cpu_spr_dat_o, model_dat(cpu_spr_addr_i));
      end else begin
        chk("cpu_gate", {cpu_spr_ack_o, cpu_spr_dat_o}, 33'd0);
        if (!busy_o) begin
          chk("arb_idle_zero", {pcu_spr_access_o, pcu_spr_we_o, pcu_spr_re_o, pcu_spr_addr_o,
              pcu_spr_dat_o}, 51'd0);
        end else if (pcu_spr_access_o) begin
          chk("arb_smp_req", {pcu_spr_we_o, pcu_spr_re_o, pcu_spr_addr_o[15:3], pcu_spr_dat_o},
              {1'b0, 1'b1, 13'h0700, 32'd0});
          chk("smp_selected", mask_i[pcu_spr_addr_o[2:0]], 1'b1);
        end
      end
      if (sample_valid_o && sample_ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_sample_idx", sample_idx_o, 3'bxxx);
        end else begin
          e = exp_q.pop_front();
          chk("sample_idx", sample_idx_o, e.idx);
          chk("sample_data", sample_data_o, e.data);
          chk("sample_last", sample_last_o, e.last);
        end
      end
      if (busy_o && !busy_prev) begin
        int hi;
        hi = -1;
        for (int i = 0; i < 8; i++) if (mask_i[i]) hi = i;
        for (int i = 0; i < 8; i++) begin
          if (mask_i[i]) exp_q.push_back('{idx: 3'(i), data: pccr[i], last: (i == hi)});
        end
      end
      busy_prev = busy_o;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_rdy) sample_ready_i = 1'($urandom_range(0, 1));
    if (rand_cpu) begin
      cpu_spr_access_i = ($urandom_range(0, 3) == 0);
      cpu_spr_re_i     = 1'($urandom_range(0, 1));
      cpu_spr_we_i     = ~cpu_spr_re_i;
      cpu_spr_addr_i   = 16'h3800 + 16'($urandom_range(0, 15));
      cpu_spr_dat_i    = $urandom;
    end
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (busy_o !== lvl && n < budget) begin
      cyc();
      n++;
    end
    if (n >= budget) chk(name, busy_o, lvl);
  endtask

  task automatic pulse_trigger();
    trigger_i = 1'b1;
    cyc();
    trigger_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int busy_cnt, seen_valid, seen_acc, k, nrec, p0;
    int vt[5];

    rst = 1'b1;
    cpu_spr_access_i = 0; cpu_spr_we_i = 0; cpu_spr_re_i = 0;
    cpu_spr_addr_i = '0; cpu_spr_dat_i = '0;
    enable_i = 0; period_i = '0; trigger_i = 0; mask_i = '0; sample_ready_i = 0;
    for (int i = 0; i < 8; i++) pccr[i] = $urandom;
    repeat (3) cyc();
    @(negedge clk);
    chk("reset_outputs", {sample_valid_o, busy_o, overrun_cnt_o, pcu_spr_access_o,
        sample_data_o, sample_idx_o, sample_last_o}, 45'd0);
    cyc();
    rst = 1'b0;

    // Trigger sweep, mask 0000_0101.
    mask_i = 8'h05; sample_ready_i = 1'b1;
    pulse_trigger();
    @(negedge clk); chk("t1_pending_not_busy", busy_o, 1'b0);
    cyc(); @(negedge clk);
    chk("t1_scan0", {busy_o, sample_valid_o, pcu_spr_access_o, pcu_spr_addr_o},
        {3'b101, 16'h3800});
    cyc(); @(negedge clk);
    chk("t1_first_valid", {busy_o, sample_valid_o, pcu_spr_access_o}, 3'b110);
    cyc(); @(negedge clk);
    chk("t1_scan2", {busy_o, pcu_spr_access_o, pcu_spr_addr_o}, {2'b11, 16'h3802});
    cyc(); @(negedge clk);
    chk("t1_done", {busy_o, sample_valid_o}, 2'b01);
    repeat (3) cyc();

    // CPU priority: CPU holds the port for the first three SCAN cycles.
    pulse_trigger();
    cpu_spr_access_i = 1'b1; cpu_spr_re_i = 1'b1; cpu_spr_addr_i = 16'h3808;
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      chk("t2_stall", {busy_o, sample_valid_o, pcu_spr_addr_o, cpu_spr_ack_o},
          {2'b10, 16'h3808, 1'b1});
    end
    cyc();
    cpu_spr_access_i = 1'b0; cpu_spr_re_i = 1'b0; cpu_spr_addr_i = '0;
    @(negedge clk);
    chk("t2_resume", {pcu_spr_access_o, pcu_spr_addr_o, sample_valid_o}, {1'b1, 16'h3800, 1'b0});
    cyc(); @(negedge clk);
    chk("t2_valid_after_resume", sample_valid_o, 1'b1);
    wait_busy(1'b0, 20, "t2_busy_timeout");
    repeat (3) cyc();

    // Empty mask: the sweep walks all eight indices without touching the PCU.
    mask_i = 8'h00;
    pulse_trigger();
    busy_cnt = 0; seen_valid = 0; seen_acc = 0;
    repeat (20) begin
      cyc();
      if (busy_o) busy_cnt++;
      if (sample_valid_o) seen_valid++;
      if (pcu_spr_access_o) seen_acc++;
    end
    chk("t3_busy_cycles", busy_cnt, 8);
    chk("t3_no_valid", seen_valid, 0);
    chk("t3_no_access", seen_acc, 0);

    // Periodic sampling, period 20.
    mask_i = 8'h01; period_i = 16'd20; enable_i = 1'b1;
    @(negedge clk);
    k = cyc_n;
    nrec = 0;
    for (int i = 0; i < 200 && nrec < 5; i++) begin
      @(negedge clk);
      if (sample_valid_o) begin
        vt[nrec] = cyc_n;
        nrec++;
      end
    end
    chk("t4_sample_count", nrec, 5);
    chk("t4_first_latency", vt[0] - k, 3);
    for (int i = 1; i < 5; i++) chk("t4_interval", vt[i] - vt[i-1], 20);
    chk("t4_no_overrun", overrun_cnt_o, 8'd0);
    cyc();
    enable_i = 1'b0;
    repeat (30) cyc();

    // Overrun: FIFO fills, SCAN stalls, overrun saturates, nothing is lost afterwards.
    p0 = pop_cnt;
    mask_i = 8'hff; sample_ready_i = 1'b0; period_i = 16'd2; enable_i = 1'b1;
    for (int i = 0; i < 1500 && overrun_cnt_o != 8'hff; i++) cyc();
    chk("t5_overrun_sat", overrun_cnt_o, 8'hff);
    chk("t5_stalled", {busy_o, sample_valid_o, pcu_spr_access_o}, 3'b110);
    repeat (10) cyc();
    chk("t5_overrun_hold", overrun_cnt_o, 8'hff);
    enable_i = 1'b0; sample_ready_i = 1'b1;
    repeat (80) cyc();
    chk("t5_drained", {busy_o, sample_valid_o}, 2'b00);
    chk("t5_scoreboard_empty", exp_q.size(), 0);
    chk("t5_samples_popped", pop_cnt - p0, 24);

    // Reset with three entries in the FIFO mid-sweep.
    sample_ready_i = 1'b0;
    pulse_trigger();
    repeat (4) cyc();
    chk("t6_pre_reset", {busy_o, sample_valid_o}, 2'b11);
    rst = 1'b1;
    cyc(); @(negedge clk);
    chk("t6_after_reset", {sample_valid_o, busy_o, overrun_cnt_o}, 10'd0);
    cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // Randomized sweeps with random CPU traffic and consumer backpressure.
    rand_rdy = 1'b1; rand_cpu = 1'b1;
    for (int it = 0; it < 40; it++) begin
      mask_i = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      for (int i = 0; i < 8; i++) pccr[i] = $urandom;
      pulse_trigger();
      wait_busy(1'b1, 20, "rnd_start_timeout");
      wait_busy(1'b0, 600, "rnd_end_timeout");
      repeat ($urandom_range(1, 4)) cyc();
    end
    rand_rdy = 1'b0; rand_cpu = 1'b0;
    cpu_spr_access_i = 1'b0; sample_ready_i = 1'b1;
    repeat (40) cyc();
    chk("rnd_scoreboard_empty", exp_q.size(), 0);
    chk("rnd_final_idle", {busy_o, sample_valid_o, overrun_cnt_o}, 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
